// File: rtl/alu_share_arbiter_if.sv
// Bundle between the requesters, the shared ALU and alu_share_arbiter.
// slave: arbiter view; master: requester/ALU view.
interface alu_share_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 32
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*3-1:0]     req_op;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [2:0]            alu_op;
    logic [WIDTH-1:0]      alu_res;
    logic                  alu_zero;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_zero;
    logic                  busy;

    modport slave (
        input  req, req_a, req_b, req_op, alu_res, alu_zero,
        output gnt, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_zero, busy
    );

    modport master (
        output req, req_a, req_b, req_op, alu_res, alu_zero,
        input  gnt, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_zero, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NREQ requesters. A winner is picked,
// its operands/op are registered onto the ALU inputs and held ALU_LAT
// cycles, then the result is captured and returned with a one-cycle pulse.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// default build is round-robin.
module alu_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] win_c;
    logic          win_vld_c;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_q;
`endif

    // Winner search: first requesting index, starting at rr_ptr (or 0) and wrapping.
    always_comb begin
        win_c     = '0;
        win_vld_c = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            if (!win_vld_c && bus.req[IW'(k)]) begin
                win_vld_c = 1'b1;
                win_c     = IW'(k);
            end
`else
            if (!win_vld_c && bus.req[IW'((32'(rr_ptr) + k) % NREQ)]) begin
                win_vld_c = 1'b1;
                win_c     = IW'((32'(rr_ptr) + k) % NREQ);
            end
`endif
        end
    end

    // Operation FSM: grant and latch operands, hold for ALU_LAT, capture, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_zero  <= 1'b0;
            bus.busy      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr        <= '0;
            win_q         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld_c) begin
                        bus.gnt    <= NREQ'(1) << win_c;
                        bus.alu_a  <= bus.req_a[32'(win_c) * WIDTH +: WIDTH];
                        bus.alu_b  <= bus.req_b[32'(win_c) * WIDTH +: WIDTH];
                        bus.alu_op <= bus.req_op[32'(win_c) * 3 +: 3];
                        cnt        <= CW'(ALU_LAT - 1);
                        bus.busy   <= 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        win_q      <= win_c;
`endif
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        bus.rsp_data  <= bus.alu_res;
                        bus.rsp_zero  <= bus.alu_zero;
                        bus.rsp_valid <= bus.gnt;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.rsp_valid <= '0;
                    bus.gnt       <= '0;
                    bus.busy      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    rr_ptr        <= IW'((32'(win_q) + 1) % NREQ);
`endif
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
